// File: rtl/io_uart_tx.sv
// -----------------------------------------------------------------------------
// io_uart_tx
//
// Serial sink for the core's memory-mapped output port. Every din_ready strobe
// pushes one 32-bit word into a small FIFO; the transmitter pops words one at a
// time and sends each as four UART frames, least significant byte first and
// least significant bit first within a byte. The core cannot be stalled, so a
// push into a full FIFO is dropped and recorded in a sticky overflow flag.
//
// Optional feature (compile-time macro IO_UART_TX_PARITY_EN):
//   defined   - an even-parity bit follows the eight data bits (8E1 frames,
//               11 bit times per byte).
//   undefined - plain 8N1 frames (10 bit times per byte).
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit time (>= 2)
//   FIFO_DEPTH    number of 32-bit word entries (power of two, >= 2)
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   din         word from the core
//   din_ready   single-cycle write strobe, sampled every rising edge
//   tx          UART serial line, idles high (registered)
//   busy        FIFO non-empty or a word in flight (combinational from state)
//   overflow    sticky: a word was dropped because the FIFO was full
//   fifo_count  number of words currently stored (registered)
// -----------------------------------------------------------------------------
module io_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   din,
    input  logic                          din_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);

`ifdef IO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;
`else
    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;
`endif

    // -------------------------------------------------------------------------
    // Word FIFO
    // -------------------------------------------------------------------------
    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;

    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push;
    logic             drop;

    // Transmitter state, declared here because the pop decision depends on it.
    state_e           state_q;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_COUNT);

    // The transmitter only takes a new word from IDLE, and only one that was
    // already stored at the previous edge (count is registered), so a word
    // pushed at edge N is popped at edge N+1 at the earliest.
    assign pop  = (state_q == StIdle) && !fifo_empty;

    // A pop on the same edge frees the head slot, so a push into a full FIFO
    // is still accepted in that case.
    assign push = din_ready && (!fifo_full || pop);
    assign drop = din_ready && fifo_full && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // Pointers are exactly PTR_W bits wide, so they wrap modulo depth.
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: stale entries are unreachable once the pointers
    // and count are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // -------------------------------------------------------------------------
    // Serialiser
    // -------------------------------------------------------------------------
    logic [31:0]       shift_q;
    logic [1:0]        byte_idx_q;
    logic [2:0]        bit_idx_q;
    logic [BAUD_W-1:0] baud_q;
    logic              tx_q;

    logic [7:0]        cur_byte;
    logic [2:0]        next_bit;
    logic              baud_done;

    // The byte on the wire always sits in the low eight bits; the register is
    // shifted down by a byte only when a frame completes.
    assign cur_byte  = shift_q[7:0];
    assign next_bit  = bit_idx_q + 3'd1;
    assign baud_done = (baud_q == BAUD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            baud_q     <= '0;
            tx_q       <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    tx_q   <= 1'b1;
                    baud_q <= '0;
                    if (!fifo_empty) begin
                        shift_q    <= mem_q[rd_ptr_q];
                        byte_idx_q <= '0;
                        bit_idx_q  <= '0;
                        tx_q       <= 1'b0;
                        state_q    <= StStart;
                    end
                end

                StStart: begin
                    if (baud_done) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= cur_byte[0];
                        state_q   <= StData;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end

                StData: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
`ifdef IO_UART_TX_PARITY_EN
                            tx_q    <= ^cur_byte;
                            state_q <= StParity;
`else
                            tx_q    <= 1'b1;
                            state_q <= StStop;
`endif
                        end else begin
                            bit_idx_q <= next_bit;
                            tx_q      <= cur_byte[next_bit];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end

`ifdef IO_UART_TX_PARITY_EN
                StParity: begin
                    if (baud_done) begin
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                        state_q <= StStop;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`endif

                StStop: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (byte_idx_q != 2'd3) begin
                            // Next byte of the same word follows with no gap.
                            byte_idx_q <= byte_idx_q + 2'd1;
                            shift_q    <= {8'h00, shift_q[31:8]};
                            tx_q       <= 1'b0;
                            state_q    <= StStart;
                        end else begin
                            // One IDLE cycle separates consecutive words.
                            tx_q    <= 1'b1;
                            state_q <= StIdle;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end

                default: begin
                    tx_q    <= 1'b1;
                    baud_q  <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign tx         = tx_q;
    assign overflow   = overflow_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != StIdle) || (count_q != '0);

endmodule

// File: tb/tb_io_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_io_uart_tx
//
// Directed bench for io_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=8. A
// free-running receiver decodes the tx line into a queue of frames (data,
// parity, start cycle, framing error); each scenario task drives its stimulus
// and compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_io_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 8;
`ifdef IO_UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif
    localparam int unsigned FRAME = FRAME_BITS * CPB;
    localparam int unsigned WORD  = 4 * FRAME;

    logic        clk;
    logic        reset;
    logic [31:0] din;
    logic        din_ready;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [3:0]  fifo_count;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;
    int unsigned cyc        = 0;
    int unsigned epoch      = 0;

    typedef struct {
        logic [7:0]  data;
        logic        par;
        int unsigned start;
        bit          ferr;
    } rx_t;

    rx_t rx_q[$];

    io_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_ready  (din_ready),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line receiver: samples mid-bit on falling clock edges; frames that
    // straddle a reset (epoch change) are discarded.
    initial begin : rx_monitor
        rx_t         r;
        int unsigned ep;
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) begin
                ep      = epoch;
                r.start = cyc;
                r.ferr  = 1'b0;
                r.par   = 1'b0;
                r.data  = 8'h00;
                repeat (CPB / 2) @(negedge clk);
                if (tx !== 1'b0) r.ferr = 1'b1;
                for (int b = 0; b < 8; b++) begin
                    repeat (CPB) @(negedge clk);
                    r.data[b] = tx;
                end
`ifdef IO_UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                r.par = tx;
`endif
                repeat (CPB) @(negedge clk);
                if (tx !== 1'b1) r.ferr = 1'b1;
                if (ep == epoch) rx_q.push_back(r);
            end
        end
    end

    task automatic get_byte(output rx_t r);
        int unsigned waited;
        waited = 0;
        while (rx_q.size() == 0 && waited < 2 * WORD) begin
            @(negedge clk);
            waited++;
        end
        if (rx_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rx_timeout: got no frame in %0d cycles, want one frame", 2 * WORD);
            r = '{data: 8'h00, par: 1'b0, start: 0, ferr: 1'b1};
        end else begin
            r = rx_q.pop_front();
        end
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        din_ready = 1'b0;
        reset     = 1'b1;
        epoch++;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (FRAME + 4) @(posedge clk);
        #1;
        rx_q.delete();
    endtask

    task automatic test_reset();
        #1;
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b want 1", tx); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        vectors++; if (fifo_count !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        do_reset();
    endtask

    task automatic test_single_word();
        int unsigned p;
        rx_t         r;
        din = 32'h44434241; din_ready = 1'b1;
        @(posedge clk); #1;
        din_ready = 1'b0;
        p = cyc;
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL single_tx_push_edge: got %b want 1", tx); end
        vectors++; if (fifo_count !== 4'd1) begin miscompares++; $display("FAIL single_count: got %0d want 1", fifo_count); end
        @(posedge clk); #1;
        vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL single_start_low: got %b want 0", tx); end
        vectors++; if (fifo_count !== 4'd0) begin miscompares++; $display("FAIL single_popped: got %0d want 0", fifo_count); end
        wait_until(p + WORD);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_last: got %b want 1", busy); end
        wait_until(p + WORD + 1);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_drop: got %b want 0", busy); end
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL single_tx_idle: got %b want 1", tx); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL single_ovf: got %b want 0", overflow); end
        for (int k = 0; k < 4; k++) begin
            get_byte(r);
            vectors++; if (r.data !== 8'(8'h41 + k) || r.ferr) begin miscompares++; $display("FAIL single_byte%0d: got %h ferr %0d want %h", k, r.data, r.ferr, 8'(8'h41 + k)); end
            if (k == 0) begin
                vectors++; if (r.start != p + 1) begin miscompares++; $display("FAIL single_start_cyc: got %0d want %0d", r.start, p + 1); end
            end
        end
    endtask

    task automatic test_overflow();
        rx_t        r;
        logic [3:0] exp_cnt;
        logic       exp_ovf;
        logic [7:0] exp_b;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            din = 32'(i); din_ready = 1'b1;
            @(posedge clk); #1;
            // Edge 1 pops word 0 while pushing word 1, so the count lags by one.
            exp_cnt = (i == 0) ? 4'd1 : ((i > 8) ? 4'd8 : 4'(i));
            exp_ovf = (i == 9);
            vectors++; if (fifo_count !== exp_cnt) begin miscompares++; $display("FAIL ovf_count_%0d: got %0d want %0d", i, fifo_count, exp_cnt); end
            vectors++; if (overflow !== exp_ovf) begin miscompares++; $display("FAIL ovf_flag_%0d: got %b want %b", i, overflow, exp_ovf); end
        end
        din_ready = 1'b0;
        for (int k = 0; k < 36; k++) begin
            get_byte(r);
            exp_b = (k % 4 == 0) ? 8'(k / 4) : 8'h00;
            vectors++; if (r.data !== exp_b || r.ferr) begin miscompares++; $display("FAIL ovf_byte%0d: got %h ferr %0d want %h", k, r.data, r.ferr, exp_b); end
        end
        repeat (2 * FRAME) @(posedge clk);
        #1;
        vectors++; if (rx_q.size() != 0) begin miscompares++; $display("FAIL ovf_extra_frames: got %0d want 0", rx_q.size()); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ovf_busy_end: got %b want 0", busy); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_back_to_back();
        rx_t         r [8];
        logic [31:0] w [2];
        int unsigned p;
        int unsigned delta;
        logic [7:0]  exp_b;
        w[0] = 32'h3C2B1A09;
        w[1] = 32'h78675645;
        do_reset();
        din = w[0]; din_ready = 1'b1;
        @(posedge clk); #1;
        p = cyc;
        din = w[1];
        @(posedge clk); #1;
        din_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            get_byte(r[k]);
            exp_b = 8'(w[k / 4] >> (8 * (k % 4)));
            vectors++; if (r[k].data !== exp_b || r[k].ferr) begin miscompares++; $display("FAIL b2b_byte%0d: got %h ferr %0d want %h", k, r[k].data, r[k].ferr, exp_b); end
        end
        vectors++; if (r[0].start != p + 1) begin miscompares++; $display("FAIL b2b_first_start: got %0d want %0d", r[0].start, p + 1); end
        for (int k = 1; k < 8; k++) begin
            delta = r[k].start - r[k - 1].start;
            if (k == 4) begin
                // Last data bit of 0x3C (and its parity) is 0, so the high run
                // is the stop bit plus the idle cycle.
                vectors++; if (delta - (FRAME_BITS - 1) * CPB != CPB + 1) begin miscompares++; $display("FAIL b2b_gap_high: got %0d want %0d", delta - (FRAME_BITS - 1) * CPB, CPB + 1); end
            end else begin
                vectors++; if (delta != FRAME) begin miscompares++; $display("FAIL b2b_delta%0d: got %0d want %0d", k, delta, FRAME); end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        rx_t         r;
        int unsigned p;
        logic [31:0] w;
        do_reset();
        din = 32'hA5C3F00F; din_ready = 1'b1;
        @(posedge clk); #1;
        p = cyc;
        din = 32'h11223344;
        @(posedge clk); #1;
        din_ready = 1'b0;
        // Inside data bit 3 of byte 1.
        wait_until(p + 1 + FRAME + 4 * CPB + 1);
        vectors++; if (fifo_count !== 4'd1) begin miscompares++; $display("FAIL rst_pre_count: got %0d want 1", fifo_count); end
        #2 reset = 1'b1;
        epoch++;
        #1;
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL rst_async_tx: got %b want 1", tx); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_async_busy: got %b want 0", busy); end
        vectors++; if (fifo_count !== 4'd0) begin miscompares++; $display("FAIL rst_async_count: got %0d want 0", fifo_count); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rst_async_ovf: got %b want 0", overflow); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (FRAME + 4) @(posedge clk);
        #1;
        rx_q.delete();
        vectors++; if (busy !== 1'b0 || tx !== 1'b1) begin miscompares++; $display("FAIL rst_stays_idle: got busy %b tx %b want busy 0 tx 1", busy, tx); end
        w = 32'h5A3CC35A;
        din = w; din_ready = 1'b1;
        @(posedge clk); #1;
        din_ready = 1'b0;
        p = cyc;
        for (int k = 0; k < 4; k++) begin
            get_byte(r);
            vectors++; if (r.data !== 8'(w >> (8 * k)) || r.ferr) begin miscompares++; $display("FAIL rst_new_byte%0d: got %h ferr %0d want %h", k, r.data, r.ferr, 8'(w >> (8 * k))); end
            if (k == 0) begin
                vectors++; if (r.start != p + 1) begin miscompares++; $display("FAIL rst_new_start: got %0d want %0d", r.start, p + 1); end
            end
        end
    endtask

    task automatic test_push_pop_full();
        rx_t         r;
        logic [31:0] w [10];
        int unsigned p0;
        logic [7:0]  exp_b;
        do_reset();
        p0 = 0;
        for (int i = 0; i < 9; i++) begin
            w[i] = 32'h01010101 * 32'(i + 1);
            din = w[i]; din_ready = 1'b1;
            @(posedge clk); #1;
            if (i == 0) p0 = cyc;
        end
        din_ready = 1'b0;
        w[9] = 32'hCAFEF00D;
        vectors++; if (fifo_count !== 4'd8) begin miscompares++; $display("FAIL full_count: got %0d want 8", fifo_count); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL full_ovf: got %b want 0", overflow); end
        // Word 0 ends at edge p0+1+WORD; the next edge pops word 1.
        wait_until(p0 + 1 + WORD);
        vectors++; if (fifo_count !== 4'd8) begin miscompares++; $display("FAIL full_pre_pop: got %0d want 8", fifo_count); end
        din = w[9]; din_ready = 1'b1;
        @(posedge clk); #1;
        din_ready = 1'b0;
        vectors++; if (fifo_count !== 4'd8) begin miscompares++; $display("FAIL full_pushpop_count: got %0d want 8", fifo_count); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL full_pushpop_ovf: got %b want 0", overflow); end
        @(posedge clk); #1;
        vectors++; if (fifo_count !== 4'd8 || busy !== 1'b1) begin miscompares++; $display("FAIL full_hold: got count %0d busy %b want 8 1", fifo_count, busy); end
        for (int k = 0; k < 40; k++) begin
            get_byte(r);
            exp_b = 8'(w[k / 4] >> (8 * (k % 4)));
            vectors++; if (r.data !== exp_b || r.ferr) begin miscompares++; $display("FAIL full_byte%0d: got %h ferr %0d want %h", k, r.data, r.ferr, exp_b); end
        end
    endtask

`ifdef IO_UART_TX_PARITY_EN
    task automatic test_parity();
        rx_t         r;
        int unsigned p;
        do_reset();
        din = 32'h000000FF; din_ready = 1'b1;
        @(posedge clk); #1;
        din_ready = 1'b0;
        p = cyc;
        wait_until(p + 176);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL par_busy_last: got %b want 1", busy); end
        wait_until(p + 177);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL par_busy_drop: got %b want 0", busy); end
        for (int k = 0; k < 4; k++) begin
            get_byte(r);
            vectors++; if (r.data !== ((k == 0) ? 8'hFF : 8'h00) || r.par !== 1'b0 || r.ferr) begin miscompares++; $display("FAIL par_ff_byte%0d: got %h par %b want %h par 0", k, r.data, r.par, (k == 0) ? 8'hFF : 8'h00); end
        end
        din = 32'h00000001; din_ready = 1'b1;
        @(posedge clk); #1;
        din_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            get_byte(r);
            vectors++; if (r.data !== ((k == 0) ? 8'h01 : 8'h00) || r.par !== (k == 0) || r.ferr) begin miscompares++; $display("FAIL par_01_byte%0d: got %h par %b want %h par %b", k, r.data, r.par, (k == 0) ? 8'h01 : 8'h00, k == 0); end
        end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        din       = 32'h0;
        din_ready = 1'b0;
        test_reset();
        test_single_word();
        test_overflow();
        test_back_to_back();
        test_reset_mid_frame();
        test_push_pop_full();
`ifdef IO_UART_TX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
